// File: rtl/eip_fetch_sequencer_pkg.sv
// Shared sizes and state encoding for the Tiny86 EIP fetch sequencer.
package eip_fetch_sequencer_pkg;

  localparam int MAX_INSTR_BYTES = 15;
  localparam int INSTR_BITS      = MAX_INSTR_BYTES * 8;

  typedef enum logic [2:0] {
    SEQ_ST_IDLE  = 3'd0,
    SEQ_ST_REQ   = 3'd1,
    SEQ_ST_RSP   = 3'd2,
    SEQ_ST_ISSUE = 3'd3,
    SEQ_ST_EXEC  = 3'd4,
    SEQ_ST_HALT  = 3'd5,
    SEQ_ST_FAULT = 3'd6
  } seq_state_e;

endpackage

// File: rtl/eip_fetch_sequencer_seq_step_counter.sv
// Retired-step counter: saturates at all-ones and flags when the next
// increment lands exactly on the step budget (budget 0 disables the flag).
module seq_step_counter #(
  parameter int unsigned STEP_W    = 32,
  parameter int unsigned MAX_STEPS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [STEP_W-1:0] count,
  output logic              budget_hit
);

  localparam logic [STEP_W-1:0] BUDGET = STEP_W'(MAX_STEPS);

  logic [STEP_W-1:0] count_next;

  assign count_next = (&count) ? count : count + STEP_W'(1);
  assign budget_hit = (MAX_STEPS != 0) && (count_next == BUDGET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/eip_fetch_sequencer.sv
// Owns the architectural EIP: fetch at EIP, hand bytes to decode, commit the
// next EIP from the control flow unit, one instruction in flight at a time.
//
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | fetch request at eip offered to instruction memory
//   RSP   | request accepted, waiting for fetch data
//   ISSUE | instruction bytes presented to decode
//   EXEC  | waiting for execute to return the next EIP
//   HALT  | stopped by halt request or step budget (sticky)
//   FAULT | stopped by a fetch error (sticky)
module eip_fetch_sequencer
  import eip_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0000_1000,
  parameter int unsigned STEP_W    = 32,
  parameter int unsigned MAX_STEPS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSTR_BITS-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [INSTR_BITS-1:0] instr_bytes,
  output logic [31:0]           instr_eip,
  input  logic                  commit_valid,
  input  logic [31:0]           commit_next_eip,
  output logic                  commit_ready,
  output logic [31:0]           eip,
  output logic [STEP_W-1:0]     step_count,
  output logic                  halted,
  output logic                  fault
);

  seq_state_e state;
  logic       req_pending;
  logic       commit_fire;
  logic       budget_hit;

  // A halt request in REQ wins over the fetch, so it masks the request itself.
  assign imem_req_valid = req_pending & ~halt_req;
  assign imem_req_addr  = eip;
  assign commit_fire    = commit_ready & commit_valid;

  seq_step_counter #(
    .STEP_W    (STEP_W),
    .MAX_STEPS (MAX_STEPS)
  ) u_step_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (commit_fire),
    .count      (step_count),
    .budget_hit (budget_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SEQ_ST_IDLE;
      eip          <= RESET_EIP;
      instr_bytes  <= '0;
      instr_eip    <= '0;
      req_pending  <= 1'b0;
      instr_valid  <= 1'b0;
      commit_ready <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      case (state)
        SEQ_ST_IDLE: begin
          if (start) begin
            eip         <= RESET_EIP;
            req_pending <= 1'b1;
            state       <= SEQ_ST_REQ;
          end
        end
        SEQ_ST_REQ: begin
          if (halt_req) begin
            req_pending <= 1'b0;
            halted      <= 1'b1;
            state       <= SEQ_ST_HALT;
          end else if (imem_req_ready) begin
            req_pending <= 1'b0;
            state       <= SEQ_ST_RSP;
          end
        end
        SEQ_ST_RSP: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              fault <= 1'b1;
              state <= SEQ_ST_FAULT;
            end else begin
              instr_bytes <= imem_rsp_data;
              instr_eip   <= eip;
              instr_valid <= 1'b1;
              state       <= SEQ_ST_ISSUE;
            end
          end
        end
        SEQ_ST_ISSUE: begin
          if (instr_ready) begin
            instr_valid  <= 1'b0;
            commit_ready <= 1'b1;
            state        <= SEQ_ST_EXEC;
          end
        end
        SEQ_ST_EXEC: begin
          if (commit_valid) begin
            eip          <= commit_next_eip;
            commit_ready <= 1'b0;
            if (halt_req || budget_hit) begin
              halted <= 1'b1;
              state  <= SEQ_ST_HALT;
            end else begin
              req_pending <= 1'b1;
              state       <= SEQ_ST_REQ;
            end
          end
        end
        SEQ_ST_HALT, SEQ_ST_FAULT: begin
        end
        default: begin
          state <= SEQ_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eip_fetch_sequencer.sv
// Bench for eip_fetch_sequencer: table vectors, randomized steps against an
// EIP/step model, and hand-written halt, budget, fault and reset sequences.
module tb_eip_fetch_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         halt_req = 1'b0;
  logic         imem_req_ready = 1'b0;
  logic         imem_rsp_valid = 1'b0;
  logic [119:0] imem_rsp_data = '0;
  logic         imem_rsp_err = 1'b0;
  logic         instr_ready = 1'b0;
  logic         commit_valid = 1'b0;
  logic [31:0]  commit_next_eip = '0;

  // a: unlimited budget, s: 2-bit counter (saturation), b: budget of 3
  logic         req_valid_a, req_valid_s, req_valid_b;
  logic [31:0]  req_addr_a, req_addr_s, req_addr_b;
  logic         instr_valid_a, instr_valid_s, instr_valid_b;
  logic [119:0] instr_bytes_a, instr_bytes_s, instr_bytes_b;
  logic [31:0]  instr_eip_a, instr_eip_s, instr_eip_b;
  logic         commit_ready_a, commit_ready_s, commit_ready_b;
  logic [31:0]  eip_a, eip_s, eip_b;
  logic [31:0]  count_a, count_b;
  logic [1:0]   count_s;
  logic         halted_a, halted_s, halted_b;
  logic         fault_a, fault_s, fault_b;

  eip_fetch_sequencer #(.RESET_EIP(32'h0000_1000), .STEP_W(32), .MAX_STEPS(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_a),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .instr_valid(instr_valid_a), .instr_ready(instr_ready), .instr_bytes(instr_bytes_a),
    .instr_eip(instr_eip_a), .commit_valid(commit_valid), .commit_next_eip(commit_next_eip),
    .commit_ready(commit_ready_a), .eip(eip_a), .step_count(count_a), .halted(halted_a), .fault(fault_a));

  eip_fetch_sequencer #(.RESET_EIP(32'h0000_1000), .STEP_W(2), .MAX_STEPS(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req_valid(req_valid_s), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_s),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .instr_valid(instr_valid_s), .instr_ready(instr_ready), .instr_bytes(instr_bytes_s),
    .instr_eip(instr_eip_s), .commit_valid(commit_valid), .commit_next_eip(commit_next_eip),
    .commit_ready(commit_ready_s), .eip(eip_s), .step_count(count_s), .halted(halted_s), .fault(fault_s));

  eip_fetch_sequencer #(.RESET_EIP(32'h0000_1000), .STEP_W(32), .MAX_STEPS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_b),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .instr_valid(instr_valid_b), .instr_ready(instr_ready), .instr_bytes(instr_bytes_b),
    .instr_eip(instr_eip_b), .commit_valid(commit_valid), .commit_next_eip(commit_next_eip),
    .commit_ready(commit_ready_b), .eip(eip_b), .step_count(count_b), .halted(halted_b), .fault(fault_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [119:0] rnd120();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[119:0];
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] sat2(input int unsigned n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; halt_req = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_err = 1'b0; instr_ready = 1'b0; commit_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_req_valid", req_valid_a, 1);
    chk("start_req_addr", req_addr_a, 32'h1000);
  endtask

  // Entered at a negedge with the DUT in REQ; leaves at the negedge after commit.
  task automatic step(input logic [31:0] exp_addr, input int req_wait, input int rsp_lat,
                      input logic [119:0] data, input int hold, input logic [31:0] next,
                      input logic hreq, input logic [31:0] exp_eip, input logic [31:0] exp_cnt,
                      input logic [1:0] exp_cnt_s);
    chk("req_valid", req_valid_a, 1);
    chk("req_addr", req_addr_a, exp_addr);
    repeat (req_wait) @(negedge clk);
    chk("req_still_valid", req_valid_a, 1);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("req_dropped", req_valid_a, 0);
    for (int i = 0; i < rsp_lat; i++) begin
      instr_ready = rbit();
      commit_valid = rbit();
      @(negedge clk);
      chk("rsp_wait_instr_valid", instr_valid_a, 0);
      chk("rsp_wait_commit_ready", commit_ready_a, 0);
    end
    instr_ready = 1'b0;
    commit_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    chk("issue_valid", instr_valid_a, 1);
    chk("issue_bytes", instr_bytes_a, data);
    chk("issue_eip", instr_eip_a, exp_addr);
    for (int i = 0; i < hold; i++) begin
      imem_rsp_valid = rbit();
      imem_rsp_data = rnd120();
      commit_valid = rbit();
      @(negedge clk);
      chk("hold_valid", instr_valid_a, 1);
      chk("hold_bytes", instr_bytes_a, data);
      chk("hold_eip", instr_eip_a, exp_addr);
    end
    imem_rsp_valid = 1'b0;
    commit_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("exec_instr_valid", instr_valid_a, 0);
    chk("exec_commit_ready", commit_ready_a, 1);
    chk("exec_eip_unchanged", eip_a, exp_addr);
    commit_valid = 1'b1;
    commit_next_eip = next;
    halt_req = hreq;
    @(negedge clk);
    commit_valid = 1'b0;
    halt_req = 1'b0;
    chk("commit_eip", eip_a, exp_eip);
    chk("commit_count", count_a, exp_cnt);
    chk("commit_count_sat", count_s, exp_cnt_s);
    chk("commit_ready_drop", commit_ready_a, 0);
    chk("commit_halted", halted_a, hreq);
    chk("commit_next_req", req_valid_a, !hreq);
  endtask

  typedef struct {
    logic [31:0] next;
    int          rsp_lat;
    int          hold;
    logic [31:0] exp_addr;
    logic [31:0] exp_eip;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t        vecs[4];
  logic [31:0] model_eip;
  int unsigned model_cnt;
  logic [31:0] nxt;
  logic [119:0] d;

  initial begin
    vecs[0] = '{32'h0000_1003, 2, 0, 32'h0000_1000, 32'h0000_1003, 32'd1};
    vecs[1] = '{32'h0000_1010, 0, 5, 32'h0000_1003, 32'h0000_1010, 32'd2};
    vecs[2] = '{32'hFFFF_FFF0, 1, 1, 32'h0000_1010, 32'hFFFF_FFF0, 32'd3};
    vecs[3] = '{32'h0000_0004, 3, 2, 32'hFFFF_FFF0, 32'h0000_0004, 32'd4};

    do_reset();
    chk("rst_eip", eip_a, 32'h1000);
    chk("rst_count", count_a, 0);
    chk("rst_bytes", instr_bytes_a, 0);
    chk("rst_req_valid", req_valid_a, 0);
    chk("rst_instr_valid", instr_valid_a, 0);
    chk("rst_commit_ready", commit_ready_a, 0);
    chk("rst_halted", halted_a, 0);
    chk("rst_fault", fault_a, 0);

    // Stray handshakes in IDLE are ignored.
    imem_rsp_valid = 1'b1; imem_rsp_data = rnd120(); instr_ready = 1'b1; commit_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0; instr_ready = 1'b0; commit_valid = 1'b0;
    @(negedge clk);
    chk("idle_req_valid", req_valid_a, 0);
    chk("idle_instr_valid", instr_valid_a, 0);
    chk("idle_bytes", instr_bytes_a, 0);
    chk("idle_count", count_a, 0);

    do_start();
    for (int v = 0; v < 4; v++) begin
      step(vecs[v].exp_addr, 0, vecs[v].rsp_lat, rnd120(), vecs[v].hold, vecs[v].next, 1'b0,
           vecs[v].exp_eip, vecs[v].exp_cnt, sat2(vecs[v].exp_cnt));
    end

    model_eip = 32'h0000_0004;
    model_cnt = 4;
    for (int n = 0; n < 20; n++) begin
      nxt = $urandom;
      step(model_eip, $urandom_range(0, 2), $urandom_range(0, 3), rnd120(), $urandom_range(0, 3),
           nxt, 1'b0, nxt, model_cnt + 1, sat2(model_cnt + 1));
      model_eip = nxt;
      model_cnt++;
    end

    // Halt raised on the commit edge: commit lands, then HALT holds.
    step(model_eip, 0, 1, rnd120(), 0, 32'h2000, 1'b1, 32'h2000, model_cnt + 1, sat2(model_cnt + 1));
    model_cnt++;
    for (int i = 0; i < 4; i++) begin
      commit_valid = 1'b1; commit_next_eip = 32'hDEAD_BEEF; imem_req_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("halt_hold_eip", eip_a, 32'h2000);
      chk("halt_hold_count", count_a, model_cnt);
      chk("halt_hold_halted", halted_a, 1);
      chk("halt_no_req", req_valid_a, 0);
    end
    commit_valid = 1'b0; imem_req_ready = 1'b0; start = 1'b0;

    // Step budget of 3 on dut_b with a jump loop to 0x1000.
    do_reset();
    chk("b_rst_count", count_b, 0);
    do_start();
    for (int i = 0; i < 3; i++) begin
      step(32'h1000, 0, 1, rnd120(), 0, 32'h1000, 1'b0, 32'h1000, i + 1, sat2(i + 1));
      chk("b_halted", halted_b, i == 2);
    end
    chk("b_count", count_b, 3);
    chk("b_eip", eip_b, 32'h1000);
    for (int i = 0; i < 4; i++) begin
      imem_req_ready = 1'b1;
      @(negedge clk);
      chk("b_no_4th_req", req_valid_b, 0);
      chk("b_count_hold", count_b, 3);
    end
    imem_req_ready = 1'b0;

    // Fetch error on the first fetch.
    do_reset();
    do_start();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = rnd120();
    @(negedge clk);
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    chk("fault_flag", fault_a, 1);
    chk("fault_not_halted", halted_a, 0);
    chk("fault_bytes", instr_bytes_a, 0);
    chk("fault_eip", eip_a, 32'h1000);
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = rbit(); imem_rsp_data = rnd120(); instr_ready = rbit();
      @(negedge clk);
      chk("fault_no_instr", instr_valid_a, 0);
      chk("fault_sticky", fault_a, 1);
      chk("fault_no_req", req_valid_a, 0);
    end
    imem_rsp_valid = 1'b0; instr_ready = 1'b0;

    // Reset while in RSP, then a late response after release.
    do_reset();
    do_start();
    step(32'h1000, 0, 0, rnd120(), 0, 32'h1234, 1'b0, 32'h1234, 1, 2'd1);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_eip", eip_a, 32'h1000);
    chk("async_count", count_a, 0);
    chk("async_bytes", instr_bytes_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d = rnd120();
    imem_rsp_valid = 1'b1; imem_rsp_data = d;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rsp_instr_valid", instr_valid_a, 0);
      chk("late_rsp_bytes", instr_bytes_a, 0);
      chk("late_rsp_req_valid", req_valid_a, 0);
    end
    chk("late_rsp_eip", eip_a, 32'h1000);

    // Halt request in REQ masks the fetch and halts.
    do_reset();
    do_start();
    halt_req = 1'b1; imem_req_ready = 1'b1;
    #1;
    chk("req_halt_masked", req_valid_a, 0);
    @(negedge clk);
    halt_req = 1'b0; imem_req_ready = 1'b0;
    chk("req_halt_halted", halted_a, 1);
    chk("req_halt_count", count_a, 0);
    @(negedge clk);
    chk("req_halt_no_req", req_valid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
